// File: rtl/pic_pkg.sv
// -----------------------------------------------------------------------------
// pic_pkg
// Shared constants and types for the 8259A host sequencer.
//   OCW2/OCW3 command bytes used for EOI and status reads.
//   op_kind_t  : kind of a single PIC bus cycle (write, read, INTA pulse).
//   seq_kind_t : which requester owns the bus for the current sequence.
//   bus_op_t   : one step of a sequence as handed to the bus-cycle engine.
// -----------------------------------------------------------------------------
package pic_pkg;

  localparam logic [7:0] OCW2_NSEOI  = 8'h20;
  localparam logic [7:0] OCW2_SEOI   = 8'h60;
  localparam logic [7:0] OCW3_RD_IRR = 8'h0A;
  localparam logic [7:0] OCW3_RD_ISR = 8'h0B;

  typedef enum logic [1:0] {
    OP_WR,
    OP_RD,
    OP_INTA
  } op_kind_t;

  typedef enum logic [2:0] {
    SEQ_INIT,
    SEQ_INTA,
    SEQ_EOI,
    SEQ_MASK,
    SEQ_READ
  } seq_kind_t;

  typedef struct packed {
    op_kind_t   kind;
    logic       a0;
    logic [7:0] data;
  } bus_op_t;

endpackage

// File: rtl/pic_bus_cycle.sv
// -----------------------------------------------------------------------------
// pic_bus_cycle
// One strobe + recovery engine for the 8259A bus. A start pulse launches a
// cycle of the given kind: the selected strobes go low for STROBE_CYCLES
// clocks, then all strobes are high for RECOVER_CYCLES clocks. A new start
// presented on the last recovery clock launches the next cycle back-to-back.
// Ports:
//   clock, reset_n          clock and synchronous active-low reset
//   start                   launch a cycle (accepted in idle or last recover clock)
//   kind, a0, wdata         cycle kind, A0 and write data for the launched cycle
//   pic_data_in             PIC data bus, sampled on the last strobe clock
//   strobe_last             high on the last strobe clock
//   done                    high on the last recovery clock
//   rdata                   data sampled at the end of the strobe phase
//   chip_select_n .. interrupt_acknowledge_n, address, pic_data_out  PIC pins
// -----------------------------------------------------------------------------
module pic_bus_cycle
  import pic_pkg::*;
#(
  parameter int STROBE_CYCLES  = 1,
  parameter int RECOVER_CYCLES = 1
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       start,
  input  op_kind_t   kind,
  input  logic       a0,
  input  logic [7:0] wdata,
  input  logic [7:0] pic_data_in,
  output logic       strobe_last,
  output logic       done,
  output logic [7:0] rdata,
  output logic       chip_select_n,
  output logic       read_enable_n,
  output logic       write_enable_n,
  output logic       interrupt_acknowledge_n,
  output logic       address,
  output logic [7:0] pic_data_out
);

  localparam int MAXC = (STROBE_CYCLES > RECOVER_CYCLES) ? STROBE_CYCLES : RECOVER_CYCLES;
  localparam int CW   = (MAXC < 1) ? 1 : $clog2(MAXC + 1);
  localparam logic [CW-1:0] S_LAST = CW'(STROBE_CYCLES - 1);
  localparam logic [CW-1:0] R_LAST = CW'(RECOVER_CYCLES - 1);

  localparam logic [1:0] PH_IDLE    = 2'd0;
  localparam logic [1:0] PH_STROBE  = 2'd1;
  localparam logic [1:0] PH_RECOVER = 2'd2;

  logic [1:0]    phase;
  logic [CW-1:0] cnt;

  // Pin values for a cycle about to launch. INTA cycles leave CS# high and
  // drive neither A0 nor data.
  logic       l_cs_n, l_rd_n, l_wr_n, l_inta_n, l_addr;
  logic [7:0] l_data;
  assign l_cs_n   = (kind == OP_INTA);
  assign l_rd_n   = (kind != OP_RD);
  assign l_wr_n   = (kind != OP_WR);
  assign l_inta_n = (kind != OP_INTA);
  assign l_addr   = (kind == OP_INTA) ? 1'b0 : a0;
  assign l_data   = (kind == OP_WR) ? wdata : 8'h00;

  assign strobe_last = (phase == PH_STROBE)  && (cnt == S_LAST);
  assign done        = (phase == PH_RECOVER) && (cnt == R_LAST);

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      phase                   <= PH_IDLE;
      cnt                     <= '0;
      chip_select_n           <= 1'b1;
      read_enable_n           <= 1'b1;
      write_enable_n          <= 1'b1;
      interrupt_acknowledge_n <= 1'b1;
      address                 <= 1'b0;
      pic_data_out            <= 8'h00;
      rdata                   <= 8'h00;
    end else begin
      case (phase)
        PH_STROBE: begin
          if (cnt == S_LAST) begin
            // strobe -> recover: release everything, capture the bus
            phase                   <= PH_RECOVER;
            cnt                     <= '0;
            chip_select_n           <= 1'b1;
            read_enable_n           <= 1'b1;
            write_enable_n          <= 1'b1;
            interrupt_acknowledge_n <= 1'b1;
            address                 <= 1'b0;
            pic_data_out            <= 8'h00;
            rdata                   <= pic_data_in;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        PH_RECOVER: begin
          if (cnt == R_LAST) begin
            // recover -> strobe (back-to-back) or idle
            cnt <= '0;
            if (start) begin
              phase                   <= PH_STROBE;
              chip_select_n           <= l_cs_n;
              read_enable_n           <= l_rd_n;
              write_enable_n          <= l_wr_n;
              interrupt_acknowledge_n <= l_inta_n;
              address                 <= l_addr;
              pic_data_out            <= l_data;
            end else begin
              phase <= PH_IDLE;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          // idle -> strobe
          cnt <= '0;
          if (start) begin
            phase                   <= PH_STROBE;
            chip_select_n           <= l_cs_n;
            read_enable_n           <= l_rd_n;
            write_enable_n          <= l_wr_n;
            interrupt_acknowledge_n <= l_inta_n;
            address                 <= l_addr;
            pic_data_out            <= l_data;
          end else begin
            phase <= PH_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/pic_host_sequencer.sv
// -----------------------------------------------------------------------------
// pic_host_sequencer
// Host-side bus master for an 8259A PIC. Arbitrates init, INTA, EOI, mask and
// status-read requests onto one PIC bus and walks each request's list of bus
// cycles through a pic_bus_cycle engine.
// Ports:
//   clock, reset_n                       clock, synchronous active-low reset
//   init_start/init_ready, cfg_icw1..4, cfg_ocw1, init_done   init sequence
//   mask_valid/mask_ready, mask_data     OCW1 write
//   eoi_valid/eoi_ready, eoi_specific, eoi_level              OCW2 EOI write
//   rd_valid/rd_ready, rd_isr, rd_data, rd_done               IRR/ISR read
//   int_vector, int_vector_valid         vector captured by INTA
//   busy                                 sequencer not idle
//   pic_interrupt, pic_data_in           from the PIC
//   chip_select_n, read_enable_n, write_enable_n,
//   interrupt_acknowledge_n, address, pic_data_out             to the PIC
// -----------------------------------------------------------------------------
module pic_host_sequencer
  import pic_pkg::*;
#(
  parameter int STROBE_CYCLES  = 1,
  parameter int RECOVER_CYCLES = 1
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       init_start,
  output logic       init_ready,
  input  logic [7:0] cfg_icw1,
  input  logic [7:0] cfg_icw2,
  input  logic [7:0] cfg_icw3,
  input  logic [7:0] cfg_icw4,
  input  logic [7:0] cfg_ocw1,
  output logic       init_done,
  input  logic       mask_valid,
  output logic       mask_ready,
  input  logic [7:0] mask_data,
  input  logic       eoi_valid,
  output logic       eoi_ready,
  input  logic       eoi_specific,
  input  logic [2:0] eoi_level,
  input  logic       rd_valid,
  output logic       rd_ready,
  input  logic       rd_isr,
  output logic [7:0] rd_data,
  output logic       rd_done,
  output logic [7:0] int_vector,
  output logic       int_vector_valid,
  output logic       busy,
  input  logic       pic_interrupt,
  input  logic [7:0] pic_data_in,
  output logic       chip_select_n,
  output logic       read_enable_n,
  output logic       write_enable_n,
  output logic       interrupt_acknowledge_n,
  output logic       address,
  output logic [7:0] pic_data_out
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ARB     = 2'd1;
  localparam logic [1:0] ST_STROBE  = 2'd2;
  localparam logic [1:0] ST_RECOVER = 2'd3;

  logic [1:0] state;
  seq_kind_t  seq_q;
  logic [2:0] step_q;
  logic [7:0] icw1_q, icw2_q, icw3_q, icw4_q, ocw1_q, wdata_q;

  logic       grant_any;
  seq_kind_t  grant_seq;
  logic       seq_last;
  logic [2:0] issue_step;
  bus_op_t    issue_op;
  logic       eng_start, eng_strobe_last, eng_done;
  logic [7:0] eng_rdata;

  // Bus cycle for a given step of the latched sequence.
  function automatic bus_op_t op_of(input seq_kind_t seq, input logic [2:0] step);
    bus_op_t op;
    op.kind = OP_WR;
    op.a0   = 1'b0;
    op.data = 8'h00;
    case (seq)
      SEQ_INIT: begin
        op.a0 = (step != 3'd0);
        case (step)
          3'd0:    op.data = icw1_q;
          3'd1:    op.data = icw2_q;
          3'd2:    op.data = icw3_q;
          3'd3:    op.data = icw4_q;
          default: op.data = ocw1_q;
        endcase
      end
      SEQ_INTA: op.kind = OP_INTA;
      SEQ_EOI:  op.data = wdata_q;
      SEQ_MASK: begin
        op.a0   = 1'b1;
        op.data = wdata_q;
      end
      SEQ_READ: begin
        if (step == 3'd0) op.data = wdata_q;
        else              op.kind = OP_RD;
      end
      default: op.kind = OP_WR;
    endcase
    return op;
  endfunction

  // Init steps: 0 ICW1, 1 ICW2, 2 ICW3, 3 ICW4, 4 OCW1. ICW1[1] (single)
  // drops ICW3, ICW1[0] (IC4) keeps ICW4.
  function automatic logic [2:0] next_step(input seq_kind_t seq, input logic [2:0] step,
                                           input logic [1:0] mode);
    logic [2:0] nxt;
    nxt = step + 3'd1;
    if (seq == SEQ_INIT) begin
      if ((step == 3'd1) && mode[1]) nxt = mode[0] ? 3'd3 : 3'd4;
      else if ((step == 3'd2) && !mode[0]) nxt = 3'd4;
    end
    return nxt;
  endfunction

  function automatic logic is_last(input seq_kind_t seq, input logic [2:0] step);
    logic last;
    case (seq)
      SEQ_INIT: last = (step == 3'd4);
      SEQ_INTA: last = (step == 3'd1);
      SEQ_READ: last = (step == 3'd1);
      default:  last = 1'b1;
    endcase
    return last;
  endfunction

  // Fixed priority; only init is eligible until init_done.
  always_comb begin
    grant_any = 1'b1;
    grant_seq = SEQ_INIT;
    if (init_start)                      grant_seq = SEQ_INIT;
    else if (init_done && pic_interrupt) grant_seq = SEQ_INTA;
    else if (init_done && eoi_valid)     grant_seq = SEQ_EOI;
    else if (init_done && mask_valid)    grant_seq = SEQ_MASK;
    else if (init_done && rd_valid)      grant_seq = SEQ_READ;
    else                                 grant_any = 1'b0;
  end

  always_comb begin
    seq_last   = is_last(seq_q, step_q);
    issue_step = (state == ST_ARB) ? 3'd0 : next_step(seq_q, step_q, icw1_q[1:0]);
    issue_op   = op_of(seq_q, issue_step);
    eng_start  = (state == ST_ARB) || ((state == ST_RECOVER) && eng_done && !seq_last);
  end

  assign busy = (state != ST_IDLE);

  pic_bus_cycle #(
    .STROBE_CYCLES (STROBE_CYCLES),
    .RECOVER_CYCLES(RECOVER_CYCLES)
  ) u_cycle (
    .clock                  (clock),
    .reset_n                (reset_n),
    .start                  (eng_start),
    .kind                   (issue_op.kind),
    .a0                     (issue_op.a0),
    .wdata                  (issue_op.data),
    .pic_data_in            (pic_data_in),
    .strobe_last            (eng_strobe_last),
    .done                   (eng_done),
    .rdata                  (eng_rdata),
    .chip_select_n          (chip_select_n),
    .read_enable_n          (read_enable_n),
    .write_enable_n         (write_enable_n),
    .interrupt_acknowledge_n(interrupt_acknowledge_n),
    .address                (address),
    .pic_data_out           (pic_data_out)
  );

  // Request fields are captured on the accepting clock.
  always_ff @(posedge clock) begin
    if ((state == ST_IDLE) && grant_any) begin
      case (grant_seq)
        SEQ_INIT: begin
          icw1_q <= cfg_icw1;
          icw2_q <= cfg_icw2;
          icw3_q <= cfg_icw3;
          icw4_q <= cfg_icw4;
          ocw1_q <= cfg_ocw1;
        end
        SEQ_EOI:  wdata_q <= eoi_specific ? (OCW2_SEOI | {5'b0, eoi_level}) : OCW2_NSEOI;
        SEQ_MASK: wdata_q <= mask_data;
        SEQ_READ: wdata_q <= rd_isr ? OCW3_RD_ISR : OCW3_RD_IRR;
        default:  wdata_q <= wdata_q;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state            <= ST_IDLE;
      seq_q            <= SEQ_INIT;
      step_q           <= 3'd0;
      init_ready       <= 1'b0;
      mask_ready       <= 1'b0;
      eoi_ready        <= 1'b0;
      rd_ready         <= 1'b0;
      init_done        <= 1'b0;
      rd_data          <= 8'h00;
      rd_done          <= 1'b0;
      int_vector       <= 8'h00;
      int_vector_valid <= 1'b0;
    end else begin
      init_ready       <= 1'b0;
      mask_ready       <= 1'b0;
      eoi_ready        <= 1'b0;
      rd_ready         <= 1'b0;
      rd_done          <= 1'b0;
      int_vector_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          // idle -> arb: grant and accept
          if (grant_any) begin
            state  <= ST_ARB;
            seq_q  <= grant_seq;
            step_q <= 3'd0;
            case (grant_seq)
              SEQ_INIT: begin
                init_ready <= 1'b1;
                init_done  <= 1'b0;
              end
              SEQ_EOI:  eoi_ready  <= 1'b1;
              SEQ_MASK: mask_ready <= 1'b1;
              SEQ_READ: rd_ready   <= 1'b1;
              default:  init_ready <= 1'b0;
            endcase
          end
        end
        ST_ARB: state <= ST_STROBE;
        ST_STROBE: begin
          if (eng_strobe_last) state <= ST_RECOVER;
        end
        default: begin
          // recover -> next step, or retire the sequence
          if (eng_done) begin
            if (!seq_last) begin
              state  <= ST_STROBE;
              step_q <= issue_step;
            end else begin
              state <= ST_IDLE;
              case (seq_q)
                SEQ_INIT: init_done <= 1'b1;
                SEQ_INTA: begin
                  int_vector       <= eng_rdata;
                  int_vector_valid <= 1'b1;
                end
                SEQ_READ: begin
                  rd_data <= eng_rdata;
                  rd_done <= 1'b1;
                end
                default: rd_done <= 1'b0;
              endcase
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pic_host_sequencer.sv
// -----------------------------------------------------------------------------
// tb_pic_host_sequencer
// Directed bench for pic_host_sequencer with STROBE=RECOVER=1. A small PIC
// responder returns vector 0x23 on the second INTA pulse, IRR=0x5A / ISR=0x00
// on reads. Expected bus and result events are queued by the stimulus and
// consumed by a monitor on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_pic_host_sequencer;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       init_start = 1'b0;
  logic       init_ready;
  logic [7:0] cfg_icw1 = 8'h00, cfg_icw2 = 8'h00, cfg_icw3 = 8'h00, cfg_icw4 = 8'h00;
  logic [7:0] cfg_ocw1 = 8'h00;
  logic       init_done;
  logic       mask_valid = 1'b0;
  logic       mask_ready;
  logic [7:0] mask_data = 8'h00;
  logic       eoi_valid = 1'b0;
  logic       eoi_ready;
  logic       eoi_specific = 1'b0;
  logic [2:0] eoi_level = 3'd0;
  logic       rd_valid = 1'b0;
  logic       rd_ready;
  logic       rd_isr = 1'b0;
  logic [7:0] rd_data;
  logic       rd_done;
  logic [7:0] int_vector;
  logic       int_vector_valid;
  logic       busy;
  logic       pic_interrupt = 1'b0;
  logic [7:0] pic_data_in;
  logic       chip_select_n, read_enable_n, write_enable_n, interrupt_acknowledge_n;
  logic       address;
  logic [7:0] pic_data_out;

  always #5 clock = ~clock;

  pic_host_sequencer #(.STROBE_CYCLES(1), .RECOVER_CYCLES(1)) dut (
    .clock(clock), .reset_n(reset_n),
    .init_start(init_start), .init_ready(init_ready),
    .cfg_icw1(cfg_icw1), .cfg_icw2(cfg_icw2), .cfg_icw3(cfg_icw3), .cfg_icw4(cfg_icw4),
    .cfg_ocw1(cfg_ocw1), .init_done(init_done),
    .mask_valid(mask_valid), .mask_ready(mask_ready), .mask_data(mask_data),
    .eoi_valid(eoi_valid), .eoi_ready(eoi_ready), .eoi_specific(eoi_specific),
    .eoi_level(eoi_level),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_isr(rd_isr), .rd_data(rd_data),
    .rd_done(rd_done),
    .int_vector(int_vector), .int_vector_valid(int_vector_valid), .busy(busy),
    .pic_interrupt(pic_interrupt), .pic_data_in(pic_data_in),
    .chip_select_n(chip_select_n), .read_enable_n(read_enable_n),
    .write_enable_n(write_enable_n), .interrupt_acknowledge_n(interrupt_acknowledge_n),
    .address(address), .pic_data_out(pic_data_out)
  );

  // ---------------- PIC responder ----------------
  logic inta_cnt = 1'b0;
  logic sel_isr = 1'b0;

  always_comb begin
    pic_data_in = 8'hFF;
    if (!interrupt_acknowledge_n && inta_cnt) pic_data_in = 8'h23;
    else if (!chip_select_n && !read_enable_n) pic_data_in = sel_isr ? 8'h00 : 8'h5A;
  end

  always @(posedge clock) begin
    if (!reset_n) inta_cnt <= 1'b0;
    else if (!interrupt_acknowledge_n) inta_cnt <= ~inta_cnt;
    if (!chip_select_n && !write_enable_n && !address && (pic_data_out[4:3] == 2'b01))
      sel_isr <= pic_data_out[0];
  end

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_bad = 0;
  int early = 0;
  logic [15:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] ev_w(input logic a0, input logic [7:0] d);
    return {4'h1, 3'b000, a0, d};
  endfunction
  function automatic logic [15:0] ev_v(input logic [7:0] d);
    return {8'h40, d};
  endfunction
  function automatic logic [15:0] ev_d(input logic [7:0] d);
    return {8'h50, d};
  endfunction
  localparam logic [15:0] EV_R = 16'h2000;
  localparam logic [15:0] EV_I = 16'h3000;
  localparam logic [15:0] EV_N = 16'h6000;

  task automatic observe(input string name, input logic [15:0] ev);
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s unexpected: got %h expected none", name, ev);
    end else begin
      check(name, {16'h0, ev}, {16'h0, exp_q.pop_front()});
    end
  endtask

  logic w_now, r_now, i_now;
  logic w_prev = 1'b0, r_prev = 1'b0, i_prev = 1'b0, d_prev = 1'b0;
  assign w_now = !chip_select_n && !write_enable_n;
  assign r_now = !chip_select_n && !read_enable_n;
  assign i_now = !interrupt_acknowledge_n;

  always @(negedge clock) begin
    if (w_now && !w_prev) observe("bus_write", ev_w(address, pic_data_out));
    if (r_now && !r_prev) observe("bus_read", {7'h10, address, 8'h00});
    if (i_now && !i_prev) observe("inta_pulse", EV_I);
    if (int_vector_valid) observe("int_vector", ev_v(int_vector));
    if (rd_done) observe("rd_data", ev_d(rd_data));
    if (init_done && !d_prev) observe("init_done", EV_N);
    if ((eoi_ready || mask_ready || rd_ready) && !init_done) early <= early + 1;
    w_prev <= w_now;
    r_prev <= r_now;
    i_prev <= i_now;
    d_prev <= init_done;
  end

  // ---------------- stimulus helpers ----------------
  task automatic run_quiet(input string name);
    bit fin = 1'b0;
    for (int k = 0; k < 300; k++) begin
      @(posedge clock); #1;
      if (init_ready) init_start = 1'b0;
      if (eoi_ready) eoi_valid = 1'b0;
      if (mask_ready) mask_valid = 1'b0;
      if (rd_ready) rd_valid = 1'b0;
      if (!interrupt_acknowledge_n) pic_interrupt = 1'b0;
      if (!init_start && !eoi_valid && !mask_valid && !rd_valid && !pic_interrupt && !busy) begin
        fin = 1'b1;
        break;
      end
    end
    check({name, "_completes"}, {31'h0, fin}, 32'h1);
    repeat (3) @(posedge clock);
    #1;
    check({name, "_queue_empty"}, exp_q.size(), 32'h0);
  endtask

  task automatic set_init(input logic [7:0] i1, input logic [7:0] i2, input logic [7:0] i3,
                          input logic [7:0] i4, input logic [7:0] o1);
    cfg_icw1 = i1; cfg_icw2 = i2; cfg_icw3 = i3; cfg_icw4 = i4; cfg_ocw1 = o1;
    init_start = 1'b1;
  endtask

  initial begin
    bit found;
    repeat (3) @(posedge clock);
    #1;
    check("rst_cs_n", {31'h0, chip_select_n}, 32'h1);
    check("rst_rd_n", {31'h0, read_enable_n}, 32'h1);
    check("rst_wr_n", {31'h0, write_enable_n}, 32'h1);
    check("rst_inta_n", {31'h0, interrupt_acknowledge_n}, 32'h1);
    check("rst_address", {31'h0, address}, 32'h0);
    check("rst_pic_data_out", {24'h0, pic_data_out}, 32'h0);
    check("rst_rd_data", {24'h0, rd_data}, 32'h0);
    check("rst_int_vector", {24'h0, int_vector}, 32'h0);
    check("rst_busy", {31'h0, busy}, 32'h0);
    check("rst_init_done", {31'h0, init_done}, 32'h0);
    check("rst_readies", {28'h0, init_ready, eoi_ready, mask_ready, rd_ready}, 32'h0);
    reset_n = 1'b1;
    @(posedge clock); #1;

    // Init without ICW3, with an IRR read held across the init.
    exp_q.push_back(ev_w(1'b0, 8'h13));
    exp_q.push_back(ev_w(1'b1, 8'h20));
    exp_q.push_back(ev_w(1'b1, 8'h03));
    exp_q.push_back(ev_w(1'b1, 8'h00));
    exp_q.push_back(EV_N);
    exp_q.push_back(ev_w(1'b0, 8'h0A));
    exp_q.push_back(EV_R);
    exp_q.push_back(ev_d(8'h5A));
    set_init(8'h13, 8'h20, 8'h77, 8'h03, 8'h00);
    rd_isr = 1'b0;
    rd_valid = 1'b1;
    run_quiet("init_single");
    check("init_single_done", {31'h0, init_done}, 32'h1);

    // Re-init with ICW3; EOI and mask held from the same clock wait for init_done.
    exp_q.push_back(ev_w(1'b0, 8'h11));
    exp_q.push_back(ev_w(1'b1, 8'h20));
    exp_q.push_back(ev_w(1'b1, 8'h04));
    exp_q.push_back(ev_w(1'b1, 8'h01));
    exp_q.push_back(ev_w(1'b1, 8'hF0));
    exp_q.push_back(EV_N);
    exp_q.push_back(ev_w(1'b0, 8'h20));
    exp_q.push_back(ev_w(1'b1, 8'hA5));
    set_init(8'h11, 8'h20, 8'h04, 8'h01, 8'hF0);
    eoi_specific = 1'b0;
    eoi_valid = 1'b1;
    mask_data = 8'hA5;
    mask_valid = 1'b1;
    run_quiet("init_cascade");
    check("no_ready_before_init_done", early, 32'h0);

    // IR3 interrupt: two INTA pulses, vector 0x23; request drops after pulse 1.
    exp_q.push_back(EV_I);
    exp_q.push_back(EV_I);
    exp_q.push_back(ev_v(8'h23));
    pic_interrupt = 1'b1;
    run_quiet("inta");

    // INTA outranks EOI presented on the same clock.
    exp_q.push_back(EV_I);
    exp_q.push_back(EV_I);
    exp_q.push_back(ev_v(8'h23));
    exp_q.push_back(ev_w(1'b0, 8'h20));
    pic_interrupt = 1'b1;
    eoi_specific = 1'b0;
    eoi_valid = 1'b1;
    run_quiet("inta_vs_eoi");

    // Specific EOI for IR3, then ISR and IRR reads.
    exp_q.push_back(ev_w(1'b0, 8'h63));
    eoi_specific = 1'b1;
    eoi_level = 3'd3;
    eoi_valid = 1'b1;
    run_quiet("eoi_specific");
    exp_q.push_back(ev_w(1'b0, 8'h0B));
    exp_q.push_back(EV_R);
    exp_q.push_back(ev_d(8'h00));
    rd_isr = 1'b1;
    rd_valid = 1'b1;
    run_quiet("read_isr");
    exp_q.push_back(ev_w(1'b0, 8'h0A));
    exp_q.push_back(EV_R);
    exp_q.push_back(ev_d(8'h5A));
    rd_isr = 1'b0;
    rd_valid = 1'b1;
    run_quiet("read_irr");
    check("rd_data_held", {24'h0, rd_data}, 32'h5A);
    check("int_vector_held", {24'h0, int_vector}, 32'h23);

    // Reset during the ICW2 strobe abandons the init.
    exp_q.push_back(ev_w(1'b0, 8'h13));
    exp_q.push_back(ev_w(1'b1, 8'h20));
    set_init(8'h13, 8'h20, 8'h00, 8'h03, 8'h00);
    found = 1'b0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clock);
      if (init_ready) init_start = 1'b0;
      if (!write_enable_n && address) begin
        found = 1'b1;
        break;
      end
    end
    check("icw2_strobe_seen", {31'h0, found}, 32'h1);
    init_start = 1'b0;
    reset_n = 1'b0;
    @(posedge clock); #1;
    check("rst_mid_wr_n", {31'h0, write_enable_n}, 32'h1);
    check("rst_mid_cs_n", {31'h0, chip_select_n}, 32'h1);
    check("rst_mid_init_done", {31'h0, init_done}, 32'h0);
    check("rst_mid_busy", {31'h0, busy}, 32'h0);
    reset_n = 1'b1;
    repeat (6) @(posedge clock);
    #1;
    check("rst_mid_not_resumed", {31'h0, busy}, 32'h0);
    check("rst_mid_queue_empty", exp_q.size(), 32'h0);

    exp_q.push_back(ev_w(1'b0, 8'h13));
    exp_q.push_back(ev_w(1'b1, 8'h20));
    exp_q.push_back(ev_w(1'b1, 8'h03));
    exp_q.push_back(ev_w(1'b1, 8'h00));
    exp_q.push_back(EV_N);
    set_init(8'h13, 8'h20, 8'h00, 8'h03, 8'h00);
    run_quiet("reinit");
    check("reinit_done", {31'h0, init_done}, 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
